branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/bp_pkg.sv | 24 ++
 rtl/bp_sat_counter.sv | 12 +
 rtl/branch_predictor.sv | 106 ++++++++++
 tb/tb_branch_predictor.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: 2-bit counter encodings and
// the saturating counter next-state function.
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_cnt_e;

  // Saturating step: up on taken, down on not-taken, clamped at ST / SNT.
  function automatic logic [1:0] cnt_next(input logic [1:0] cur, input logic taken);
    logic [1:0] res;
    res = cur;
    if (taken) begin
      if (cur != ST) res = cur + 2'd1;
    end else begin
      if (cur != SNT) res = cur - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// One 2-bit saturating counter step, used on the table update path.
module bp_sat_counter
  import bp_pkg::*;
(
  input  logic [1:0] cur,
  input  logic       taken,
  output logic [1:0] next
);

  assign next = cnt_next(cur, taken);

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch predictor with 2**IDX_W two-bit counters and saturating
// resolve/mispredict statistics. Defining BP_GSHARE_EN adds an IDX_W-bit
// global history register that is XORed into the read and update indices.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned IDX_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      if_pc,
  output logic             pred_taken,
  input  logic             ex_valid,
  input  logic             ex_stall,
  input  logic [31:0]      ex_pc,
  input  logic             ex_taken,
  input  logic             ex_pred,
  output logic             flush,
  output logic             branch,
  output logic             correct,
  output logic [CNT_W-1:0] total_branch,
  output logic [CNT_W-1:0] predict_miss
);

  localparam int unsigned Entries = 2 ** IDX_W;

  logic [1:0]       tbl_q [Entries];
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic [1:0]       cnt_nxt;
  logic             update;
  logic             mispredict;
  logic             branch_q;
  logic             correct_q;
  logic [CNT_W-1:0] total_q;
  logic [CNT_W-1:0] miss_q;
  logic             unused_pc;

  assign update     = ex_valid & ~ex_stall;
  assign mispredict = update & (ex_pred != ex_taken);

`ifdef BP_GSHARE_EN
  logic [IDX_W-1:0] ghr_q;

  assign rd_idx = if_pc[IDX_W+1:2] ^ ghr_q;
  assign wr_idx = ex_pc[IDX_W+1:2] ^ ghr_q;

  // Global history: shift in each resolved outcome.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr_q <= '0;
    end else if (update) begin
      ghr_q <= {ghr_q[IDX_W-2:0], ex_taken};
    end
  end
`else
  assign rd_idx = if_pc[IDX_W+1:2];
  assign wr_idx = ex_pc[IDX_W+1:2];
`endif

  // Only the index bits of the PCs matter.
  assign unused_pc = ^{if_pc[31:IDX_W+2], if_pc[1:0], ex_pc[31:IDX_W+2], ex_pc[1:0]};

  // No bypass: the read always sees the registered (pre-update) entry.
  assign pred_taken = tbl_q[rd_idx][1];
  assign flush      = mispredict;

  bp_sat_counter u_sat_counter (
    .cur   (tbl_q[wr_idx]),
    .taken (ex_taken),
    .next  (cnt_nxt)
  );

  // Pattern table: all entries weakly not-taken after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Entries; i++) begin
        tbl_q[i] <= WNT;
      end
    end else if (update) begin
      tbl_q[wr_idx] <= cnt_nxt;
    end
  end

  // Registered per-branch status and saturating statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_q  <= 1'b0;
      correct_q <= 1'b1;
      total_q   <= '0;
      miss_q    <= '0;
    end else begin
      branch_q  <= update;
      correct_q <= ~mispredict;
      if (update && (total_q != '1)) total_q <= total_q + CNT_W'(1);
      if (mispredict && (miss_q != '1)) miss_q <= miss_q + CNT_W'(1);
    end
  end

  assign branch       = branch_q;
  assign correct      = correct_q;
  assign total_branch = total_q;
  assign predict_miss = miss_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor with a reference table model and
// a scoreboard of registered outputs. Honours BP_GSHARE_EN in the model.
module tb_branch_predictor;

  localparam int unsigned IdxW = 4;
  localparam int unsigned CntW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [31:0]     if_pc = '0;
  logic            pred_taken;
  logic            ex_valid = 1'b0;
  logic            ex_stall = 1'b0;
  logic [31:0]     ex_pc = '0;
  logic            ex_taken = 1'b0;
  logic            ex_pred = 1'b0;
  logic            flush;
  logic            branch;
  logic            correct;
  logic [CntW-1:0] total_branch;
  logic [CntW-1:0] predict_miss;

  branch_predictor #(
    .IDX_W (IdxW),
    .CNT_W (CntW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .if_pc        (if_pc),
    .pred_taken   (pred_taken),
    .ex_valid     (ex_valid),
    .ex_stall     (ex_stall),
    .ex_pc        (ex_pc),
    .ex_taken     (ex_taken),
    .ex_pred      (ex_pred),
    .flush        (flush),
    .branch       (branch),
    .correct      (correct),
    .total_branch (total_branch),
    .predict_miss (predict_miss)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            br;
    logic            cor;
    logic [CntW-1:0] tot;
    logic [CntW-1:0] mis;
  } exp_t;

  exp_t sb[$];

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state.
  logic [1:0]      m_tbl [16];
  logic [3:0]      m_ghr;
  logic [CntW-1:0] m_tot;
  logic [CntW-1:0] m_mis;

  function automatic int midx(input logic [31:0] pc);
    logic [3:0] i;
    i = pc[5:2];
`ifdef BP_GSHARE_EN
    i = i ^ m_ghr;
`endif
    return int'(i);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_tbl[i] = 2'b01;
    m_ghr = '0;
    m_tot = '0;
    m_mis = '0;
    sb.delete();
  endtask

  // Drive one cycle of stimulus, check combinational outputs, then check the
  // registered outputs popped from the scoreboard after the edge.
  task automatic step(input logic v, input logic s, input logic [31:0] ipc,
                      input logic [31:0] epc, input logic tk, input logic pr);
    exp_t e;
    exp_t got;
    logic upd;
    logic mis;
    logic exp_pred;
    int   wi;
    @(negedge clk);
    if_pc    = ipc;
    ex_valid = v;
    ex_stall = s;
    ex_pc    = epc;
    ex_taken = tk;
    ex_pred  = pr;
    #1;
    upd      = v & ~s;
    mis      = upd & (pr != tk);
    exp_pred = m_tbl[midx(ipc)][1];
    n_chk++;
    if (flush !== mis) $display("FAIL flush pc=%h got=%b exp=%b", epc, flush, mis);
    else n_pass++;
    n_chk++;
    if (pred_taken !== exp_pred)
      $display("FAIL pred_same_cycle pc=%h got=%b exp=%b", ipc, pred_taken, exp_pred);
    else n_pass++;
    if (upd && m_tot != '1) m_tot = m_tot + 1'b1;
    if (mis && m_mis != '1) m_mis = m_mis + 1'b1;
    e.br  = upd;
    e.cor = ~mis;
    e.tot = m_tot;
    e.mis = m_mis;
    sb.push_back(e);
    if (upd) begin
      wi = midx(epc);
      if (tk) begin
        if (m_tbl[wi] != 2'b11) m_tbl[wi] = m_tbl[wi] + 2'd1;
      end else begin
        if (m_tbl[wi] != 2'b00) m_tbl[wi] = m_tbl[wi] - 2'd1;
      end
      m_ghr = {m_ghr[2:0], tk};
    end
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
    got = sb.pop_front();
    n_chk++;
    if (branch !== got.br) $display("FAIL branch got=%b exp=%b", branch, got.br);
    else n_pass++;
    n_chk++;
    if (correct !== got.cor) $display("FAIL correct got=%b exp=%b", correct, got.cor);
    else n_pass++;
    n_chk++;
    if (total_branch !== got.tot)
      $display("FAIL total_branch got=%0d exp=%0d", total_branch, got.tot);
    else n_pass++;
    n_chk++;
    if (predict_miss !== got.mis)
      $display("FAIL predict_miss got=%0d exp=%0d", predict_miss, got.mis);
    else n_pass++;
  endtask

  task automatic peek(input logic [31:0] pc);
    logic exp_pred;
    if_pc = pc;
    #1;
    exp_pred = m_tbl[midx(pc)][1];
    n_chk++;
    if (pred_taken !== exp_pred)
      $display("FAIL pred pc=%h got=%b exp=%b", pc, pred_taken, exp_pred);
    else n_pass++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst      = 1'b1;
    ex_valid = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 16; i++) peek(32'(i * 4));
    n_chk++;
    if (correct !== 1'b1) $display("FAIL reset_correct got=%b exp=1", correct);
    else n_pass++;
    n_chk++;
    if (branch !== 1'b0) $display("FAIL reset_branch got=%b exp=0", branch);
    else n_pass++;
    n_chk++;
    if (total_branch !== '0 || predict_miss !== '0)
      $display("FAIL reset_counts got=%0d/%0d exp=0/0", total_branch, predict_miss);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_training();
    test_reset();
    step(1, 0, 32'h0, 32'h40, 1, 0);
    step(1, 0, 32'h0, 32'h40, 1, 0);
    peek(32'h40);
    n_chk++;
    if (predict_miss !== 4'd2 || total_branch !== 4'd2)
      $display("FAIL train_counts got=%0d/%0d exp=2/2", predict_miss, total_branch);
    else n_pass++;
  endtask

  task automatic test_saturation();
    test_reset();
    for (int i = 0; i < 5; i++) step(1, 0, 32'h8, 32'h8, 1, 1);
    peek(32'h8);
    step(1, 0, 32'h8, 32'h8, 0, 1);
    peek(32'h8);
    step(0, 0, 32'h8, 32'h8, 0, 0);
  endtask

  task automatic test_stall();
    test_reset();
    step(1, 0, 32'h4, 32'h4, 1, 0);
    step(1, 1, 32'h4, 32'h4, 1, 0);
    step(1, 1, 32'h4, 32'h4, 0, 1);
    peek(32'h4);
  endtask

  task automatic test_collision();
    test_reset();
    step(1, 0, 32'h10, 32'h10, 1, 0);
    step(1, 0, 32'h10, 32'h10, 0, 1);
    peek(32'h10);
    step(1, 0, 32'h10, 32'h10, 0, 0);
    peek(32'h10);
  endtask

  task automatic test_reset_override();
    test_reset();
    step(1, 0, 32'h20, 32'h20, 1, 0);
    step(1, 0, 32'h20, 32'h20, 1, 1);
    @(negedge clk);
    ex_valid = 1'b1;
    ex_stall = 1'b0;
    ex_pc    = 32'h20;
    ex_taken = 1'b1;
    ex_pred  = 1'b1;
    #2;
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_chk++;
    if (branch !== 1'b0) $display("FAIL override_branch got=%b exp=0", branch);
    else n_pass++;
    peek(32'h20);
    step(1, 0, 32'h20, 32'h20, 0, 0);
    peek(32'h20);
  endtask

  task automatic test_count_sat();
    test_reset();
    for (int i = 0; i < 20; i++) begin
      logic tk;
      tk = 1'(i % 3 == 0);
      step(1, 0, 32'(i * 4), 32'(i * 4), tk, ~tk);
    end
    n_chk++;
    if (total_branch !== 4'hF || predict_miss !== 4'hF)
      $display("FAIL count_sat got=%0d/%0d exp=15/15", total_branch, predict_miss);
    else n_pass++;
  endtask

  task automatic test_alternating();
    test_reset();
    for (int i = 0; i < 8; i++) step(1, 0, 32'h0, 32'h0, 1'(i % 2 == 0), 1'b0);
    for (int i = 0; i < 16; i++) peek(32'(i * 4));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    model_reset();
    #12;
    rst = 1'b0;
    test_reset();
    test_training();
    test_saturation();
    test_stall();
    test_collision();
    test_reset_override();
    test_count_sat();
    test_alternating();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
